// File: rtl/if_stage_if.sv
// Instruction-fetch stage bus bundle: imem request/response, redirect input and decode-side output.
// master = fetch stage view, slave = memory/decode/branch environment view.
interface if_stage_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc4;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output out_valid, out_inst, out_pc, out_pc4,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  out_valid, out_inst, out_pc, out_pc4,
        output out_ready
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, output register plus one-entry skid buffer,
// redirect flushes buffered words and kills the in-flight response.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        arst_n,
    if_stage_if.master  bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_STEP = XLEN'(4);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } fetch_t;

    state_e          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] tag_pc, tag_pc_next;
    logic            kill, kill_next;
    logic            armed;

    fetch_t          out_q, skid_q, resp;
    logic            out_valid_q, skid_valid_q, skid_valid_next;
    logic            consume, accept;

    assign consume = out_valid_q & bus.out_ready;
    // A response is only usable if it belongs to a live fetch and no flush happens this cycle
    assign accept  = (state == WAIT) & bus.imem_rvalid & ~kill & ~bus.redirect;

    always_comb begin
        resp.inst = bus.imem_rdata;
        resp.pc   = tag_pc;
        resp.pc4  = tag_pc + INST_STEP;
    end

    // Skid occupancy after this cycle's update; decides WAIT exit
    always_comb begin
        skid_valid_next = skid_valid_q;
        if (bus.redirect) begin
            skid_valid_next = 1'b0;
        end else if (consume) begin
            skid_valid_next = skid_valid_q & accept;
        end else if (accept && out_valid_q) begin
            skid_valid_next = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        tag_pc_next = tag_pc;
        kill_next   = kill;
        unique case (state)
            IDLE: begin
                if (bus.redirect || (armed && !skid_valid_q)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.imem_gnt) begin
                    state_next  = WAIT;
                    tag_pc_next = pc;
                    pc_next     = pc + INST_STEP;
                    kill_next   = bus.redirect;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    kill_next  = 1'b0;
                    state_next = skid_valid_next ? IDLE : REQ;
                end else if (bus.redirect) begin
                    kill_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (bus.redirect) begin
            pc_next = bus.redirect_pc;
        end
    end

    // Control state; armed delays the first request by one cycle after reset release
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            tag_pc <= '0;
            kill   <= 1'b0;
            armed  <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            tag_pc <= tag_pc_next;
            kill   <= kill_next;
            armed  <= 1'b1;
        end
    end

    // Output register and skid buffer
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_next;
            if (bus.redirect) begin
                out_valid_q <= 1'b0;
            end else if (consume) begin
                if (skid_valid_q) begin
                    out_q       <= skid_q;
                    out_valid_q <= 1'b1;
                    if (accept) begin
                        skid_q <= resp;
                    end
                end else if (accept) begin
                    out_q       <= resp;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                if (!out_valid_q) begin
                    out_q       <= resp;
                    out_valid_q <= 1'b1;
                end else begin
                    skid_q <= resp;
                end
            end
        end
    end

    assign bus.imem_req  = (state == REQ);
    assign bus.imem_addr = pc;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_q.inst;
    assign bus.out_pc    = out_q.pc;
    assign bus.out_pc4   = out_q.pc4;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model with random latency, in-order delivery scoreboard,
// table of redirect corner cases, reset and stall sequences, then random traffic.
module tb_if_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] ANY    = 32'hFFFF_FFFF;

    typedef enum int {R_NONE, R_NOW, R_GNT, R_RV, R_WAIT, R_RAND} rmode_e;

    typedef struct {
        rmode_e      mode;
        logic [31:0] match;
        logic [31:0] target;
        logic [31:0] pc0;
        logic [31:0] pc4_0;
        logic [31:0] pc1;
    } vec_t;

    logic clk;
    logic arst_n;

    if_stage_if bus ();

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          ncheck = 0;
    int          nbad   = 0;

    bit          outstanding = 0;
    logic [31:0] mem_addr    = '0;
    int          lat_left    = 0;
    bit          last_g      = 0;
    int unsigned gnt_pct     = 100;
    int unsigned ready_pct   = 100;
    int unsigned lat_min     = 1;
    int unsigned lat_max     = 1;

    rmode_e      redir_mode   = R_NONE;
    logic [31:0] redir_match  = ANY;
    logic [31:0] redir_target = '0;
    bit          fired        = 0;

    logic [31:0] exp_pc    = RST_PC;
    int          granted   = 0;
    int          delivered = 0;

    bit          hold_pend = 0;
    logic [31:0] hold_inst = '0;
    logic [31:0] hold_pc   = '0;
    bit          addr_pend = 0;
    logic [31:0] addr_prev = '0;

    logic [31:0] got_pc[$];
    logic [31:0] got_pc4[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'(a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncheck++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample outputs at negedge, run memory model and scoreboard, drive inputs
    task automatic cycle();
        logic        req, ov, g, rv, rdy, rd, in_wait;
        logic [31:0] addr, inst, opc, opc4, rdata, rpc, resp_addr;
        @(negedge clk);
        req  = bus.imem_req;
        addr = bus.imem_addr;
        ov   = bus.out_valid;
        inst = bus.out_inst;
        opc  = bus.out_pc;
        opc4 = bus.out_pc4;

        if (hold_pend) begin
            chk("hold_valid", 32'(ov), 32'd1);
            chk("hold_inst", inst, hold_inst);
            chk("hold_pc", opc, hold_pc);
            hold_pend = 0;
        end
        if (addr_pend) begin
            chk("addr_hold_req", 32'(req), 32'd1);
            chk("addr_hold", addr, addr_prev);
            addr_pend = 0;
        end
        if (outstanding) chk("req_while_waiting", 32'(req), 32'd0);

        rv = 0; in_wait = 0; rdata = $urandom(); resp_addr = mem_addr;
        if (outstanding) begin
            if (lat_left == 0) begin
                rv = 1;
                rdata = mem_word(mem_addr);
                outstanding = 0;
            end else begin
                lat_left--;
                in_wait = 1;
            end
        end

        g   = req && ($urandom_range(99) < gnt_pct);
        rdy = ($urandom_range(99) < ready_pct);
        rpc = redir_target;
        rd  = 0;
        case (redir_mode)
            R_NOW:  rd = 1;
            R_GNT:  rd = g && (redir_match == ANY || addr == redir_match);
            R_RV:   rd = rv && (redir_match == ANY || resp_addr == redir_match);
            R_WAIT: rd = in_wait && (redir_match == ANY || resp_addr == redir_match);
            R_RAND: begin
                rd  = ($urandom_range(99) < 3);
                rpc = $urandom() & 32'hFFFF_FFFC;
                if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
            end
            default: rd = 0;
        endcase
        if (rd && redir_mode != R_RAND) begin
            redir_mode = R_NONE;
            fired = 1;
        end

        last_g = g;
        if (g) begin
            outstanding = 1;
            mem_addr = addr;
            lat_left = int'($urandom_range(lat_max, lat_min)) - 1;
            granted++;
        end

        if (ov && rdy) begin
            chk("out_pc", opc, exp_pc);
            chk("out_inst", inst, mem_word(opc));
            chk("out_pc4", opc4, opc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
            got_pc.push_back(opc);
            got_pc4.push_back(opc4);
        end
        if (rd) begin
            exp_pc = rpc;
            got_pc.delete();
            got_pc4.delete();
        end

        if (ov && !rdy && !rd) begin
            hold_pend = 1; hold_inst = inst; hold_pc = opc;
        end
        if (req && !g && !rd) begin
            addr_pend = 1; addr_prev = addr;
        end

        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rdata;
        bus.out_ready   = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rd ? rpc : $urandom();
    endtask

    // Short asynchronous reset pulse between clock edges, then boot timing checks
    task automatic do_reset();
        #2 arst_n = 1'b0;
        #1;
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RST_PC);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_pc4", bus.out_pc4, 32'd0);
        bus.imem_gnt  = 1'b0;
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b0;
        if (last_g) outstanding = 0;
        last_g = 0; exp_pc = RST_PC; granted = 0; delivered = 0;
        hold_pend = 0; addr_pend = 0; redir_mode = R_NONE;
        got_pc.delete(); got_pc4.delete();
        #1 arst_n = 1'b1;
        @(posedge clk); #1;
        chk("boot_req_edge1", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("boot_req_edge2", 32'(bus.imem_req), 32'd1);
        chk("boot_addr", bus.imem_addr, RST_PC);
    endtask

    task automatic wait_got(input int n, input int bound, input string name);
        int k = 0;
        while (got_pc.size() < n && k < bound) begin
            cycle();
            k++;
        end
        chk({name, "_timeout"}, 32'(got_pc.size() >= n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[6];
        logic [31:0] exp_before;
        int          k;

        vecs[0] = '{R_WAIT, 32'h0000_0008, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104};
        vecs[1] = '{R_GNT,  ANY,           32'h0000_2000, 32'h0000_2000, 32'h0000_2004, 32'h0000_2004};
        vecs[2] = '{R_RV,   ANY,           32'h3000_0000, 32'h3000_0000, 32'h3000_0004, 32'h3000_0004};
        vecs[3] = '{R_NOW,  ANY,           32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{R_GNT,  ANY,           32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[5] = '{R_WAIT, ANY,           32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004};

        arst_n = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Basic streaming from reset
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
        wait_got(3, 40, "stream");
        for (int i = 0; i < 3; i++) begin
            chk("stream_pc", got_pc[i], RST_PC + 32'(4 * i));
            chk("stream_pc4", got_pc4[i], RST_PC + 32'(4 * i + 4));
        end

        // Decode stall: output held, one word in skid, fetching stops
        ready_pct = 0;
        exp_before = exp_pc;
        repeat (5) cycle();
        @(posedge clk); #1;
        chk("stall_req", 32'(bus.imem_req), 32'd0);
        chk("stall_buffered", 32'(granted - delivered), 32'd2);
        chk("stall_outstanding", 32'(outstanding), 32'd0);
        got_pc.delete(); got_pc4.delete();
        ready_pct = 100;
        wait_got(2, 20, "release");
        chk("release_pc0", got_pc[0], exp_before);
        chk("release_pc1", got_pc[1], exp_before + 32'd4);

        // Reset while skid buffer is full
        ready_pct = 0;
        repeat (6) cycle();
        do_reset();
        ready_pct = 100;
        wait_got(2, 30, "restart");
        chk("restart_pc0", got_pc[0], RST_PC);
        chk("restart_pc1", got_pc[1], RST_PC + 32'd4);

        // Reset with a response on the bus: stale response must be ignored
        k = 0;
        while (!bus.imem_rvalid && k < 20) begin
            cycle();
            k++;
        end
        chk("stale_resp_seen", 32'(bus.imem_rvalid), 32'd1);
        do_reset();
        wait_got(1, 30, "stale");
        chk("stale_first_pc", got_pc[0], RST_PC);

        // Redirect corner cases
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 6; i++) begin
            fired = 0;
            redir_match  = vecs[i].match;
            redir_target = vecs[i].target;
            redir_mode   = vecs[i].mode;
            k = 0;
            while (!(fired && got_pc.size() >= 2) && k < 80) begin
                cycle();
                k++;
            end
            chk("vec_fired", 32'(fired), 32'd1);
            chk("vec_pc0", got_pc[0], vecs[i].pc0);
            chk("vec_pc4_0", got_pc4[0], vecs[i].pc4_0);
            chk("vec_pc1", got_pc[1], vecs[i].pc1);
        end

        // Random traffic against the scoreboard
        gnt_pct = 70; ready_pct = 70; lat_min = 1; lat_max = 3;
        redir_mode = R_RAND;
        delivered = 0;
        repeat (3000) cycle();
        redir_mode = R_NONE;
        chk("random_liveness", 32'(delivered >= 200), 32'd1);

        $display("test done: total=%0d bad=%0d", ncheck, nbad);
        $finish;
    end
endmodule
